sobel_stream_filter: RTL and testbench

// - Streaming 3x3 Sobel edge detector for raster-order pixel streams of IMG_W x IMG_H.
// - Two internal line buffers replace whole-frame storage; sustains 1 pixel/clock with valid/ready backpressure.
// - Sits between the pixel source (camera/frame reader) and the edge-map sink in the image-filter chain.
// - Computes Gx and Gy each cycle; mode selects magnitude or signed single-axis output.

---
 rtl/sobel_pkg.sv | 21 ++
 rtl/sobel_line_buffer.sv | 27 ++
 rtl/sobel_stream_filter.sv | 195 +++++++++++++++++++
 tb/tb_sobel_stream_filter.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// sobel_pkg: mode and FSM encodings plus the output-width helper shared by
// the Sobel stream filter files.
package sobel_pkg;

  // Output selection, sampled with the start-of-frame pixel. 2'b11 behaves as MODE_MAG.
  localparam logic [1:0] MODE_MAG = 2'b00;
  localparam logic [1:0] MODE_GX  = 2'b01;
  localparam logic [1:0] MODE_GY  = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    DRAIN = 2'b10
  } sobel_state_e;

  // Three extra bits hold |Gx|+|Gy| <= 8*(2^pix_w-1) and the signed single-axis gradients.
  function automatic int out_w(input int pix_w);
    return pix_w + 3;
  endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// sobel_line_buffer: one word per column holding the two previous rows
// packed as {row r-1, row r-2}. The read is combinational so the old word is
// seen before the same-address write lands at the clock edge.
module sobel_line_buffer
  import sobel_pkg::*;
#(
  parameter int DEPTH  = 720,
  parameter int DATA_W = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  assign rdata = mem[addr];

  // Write the shifted column word back on every accepted pixel.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

endmodule

// File: rtl/sobel_stream_filter.sv
// sobel_stream_filter: streaming 3x3 Sobel edge detector with two line
// buffers, 1 pixel/clock and valid/ready backpressure.
// Optional build macro SOBEL_THRESH_EN adds the thresh input and the
// registered out_edge output.
//
// state | meaning
// IDLE  | waiting for in_sof; other pixels are accepted and dropped
// RUN   | frame in progress; every accepted pixel advances col/row
// DRAIN | last pixel taken; waiting for the out_last handshake
module sobel_stream_filter
  import sobel_pkg::*;
#(
  parameter int IMG_W = 720,
  parameter int IMG_H = 120,
  parameter int PIX_W = 8,
  parameter int OUT_W = out_w(PIX_W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       mode,
`ifdef SOBEL_THRESH_EN
  input  logic [OUT_W-1:0] thresh,
  output logic             out_edge,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sof,
  input  logic [PIX_W-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_last,
  output logic             frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  sobel_state_e state_q, state_d;

  logic [CW-1:0] col_q, cur_col;
  logic [RW-1:0] row_q, cur_row;
  logic [1:0]    mode_q;
  logic          stall, accept, pix_take, abort, last_pix, interior;

  logic [2*PIX_W-1:0]         lb_rd;
  logic [2:0][2:0][PIX_W-1:0] win_q;
  logic                       s1_valid, s1_last;

  logic signed [OUT_W-1:0] p [3][3];
  logic signed [OUT_W-1:0] gx, gy;
  logic        [OUT_W-1:0] ax, ay, mag, res;

  // Handshake: the whole pipeline freezes while the output is held.
  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall && (state_q != DRAIN);
  assign accept   = in_valid && in_ready;
  assign pix_take = accept && (in_sof || (state_q == RUN));
  assign abort    = accept && in_sof && (state_q == RUN);

  // A start-of-frame pixel is always position (0,0), even mid-frame.
  assign cur_col  = in_sof ? '0 : col_q;
  assign cur_row  = in_sof ? '0 : row_q;
  assign last_pix = (cur_row == ROW_LAST) && (cur_col == COL_LAST);
  assign interior = (cur_row >= RW'(2)) && (cur_col >= CW'(2));

  sobel_line_buffer #(
    .DEPTH  (IMG_W),
    .DATA_W (2 * PIX_W),
    .AW     (CW)
  ) u_line_buffer (
    .clk   (clk),
    .we    (pix_take),
    .addr  (cur_col),
    .wdata ({in_data, lb_rd[2*PIX_W-1:PIX_W]}),
    .rdata (lb_rd)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && in_sof) state_d = RUN;
      RUN:     if (pix_take && last_pix) state_d = DRAIN;
      DRAIN:   if (out_valid && out_ready && out_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Raster position counters and per-frame mode capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q  <= '0;
      row_q  <= '0;
      mode_q <= MODE_MAG;
    end else begin
      if (accept && in_sof) mode_q <= mode;
      if (pix_take) begin
        if (cur_col == COL_LAST) begin
          col_q <= '0;
          row_q <= cur_row + RW'(1);
        end else begin
          col_q <= cur_col + CW'(1);
          row_q <= cur_row;
        end
      end
    end
  end

  // S1: shift the 3x3 window left and load the new column (oldest row on top).
  always_ff @(posedge clk) begin
    if (pix_take) begin
      for (int r = 0; r < 3; r++) begin
        win_q[r][0] <= win_q[r][1];
        win_q[r][1] <= win_q[r][2];
      end
      win_q[0][2] <= lb_rd[PIX_W-1:0];
      win_q[1][2] <= lb_rd[2*PIX_W-1:PIX_W];
      win_q[2][2] <= in_data;
    end
  end

  // S1 valid/last tags; only interior window positions produce a result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
    end else if (!stall) begin
      s1_valid <= pix_take && interior;
      s1_last  <= pix_take && interior && last_pix;
    end
  end

  // S2 arithmetic: zero-extended pixels summed as signed OUT_W values.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        p[r][c] = $signed({{(OUT_W-PIX_W){1'b0}}, win_q[r][c]});
      end
    end
    gx  = (p[0][2] + (p[1][2] <<< 1) + p[2][2]) - (p[0][0] + (p[1][0] <<< 1) + p[2][0]);
    gy  = (p[2][0] + (p[2][1] <<< 1) + p[2][2]) - (p[0][0] + (p[0][1] <<< 1) + p[0][2]);
    ax  = gx[OUT_W-1] ? -gx : gx;
    ay  = gy[OUT_W-1] ? -gy : gy;
    mag = ax + ay;
    case (mode_q)
      MODE_GX: res = gx;
      MODE_GY: res = gy;
      default: res = mag;
    endcase
  end

  // S2 output register; an abort drops the result still sitting in S1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else if (!stall) begin
      out_valid <= s1_valid && !abort;
      out_last  <= s1_valid && s1_last && !abort;
      if (s1_valid) out_data <= res;
    end
  end

  // Pulse once when the frame's final result is handed to the sink.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_done <= 1'b0;
    else        frame_done <= (state_q == DRAIN) && out_valid && out_ready && out_last;
  end

`ifdef SOBEL_THRESH_EN
  logic [OUT_W-1:0] thresh_q;

  // Edge flag follows the magnitude regardless of mode and moves with out_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      thresh_q <= '0;
      out_edge <= 1'b0;
    end else begin
      if (accept && in_sof) thresh_q <= thresh;
      if (!stall && s1_valid) out_edge <= (mag >= thresh_q);
    end
  end
`endif

endmodule

// File: tb/tb_sobel_stream_filter.sv
// tb_sobel_stream_filter: directed 8x6 frames with hand-computed results,
// a formula-based reference for ramp images, random backpressure, frame
// abort and mid-frame reset. Define SOBEL_THRESH_EN to also cover out_edge.
module tb_sobel_stream_filter;
  import sobel_pkg::*;

  localparam int IMG_W = 8;
  localparam int IMG_H = 6;
  localparam int PIX_W = 8;
  localparam int OUT_W = PIX_W + 3;
  localparam int MASK  = (1 << OUT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic [1:0]       mode = 2'b00;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             in_sof = 1'b0;
  logic [PIX_W-1:0] in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [OUT_W-1:0] out_data;
  logic             out_last;
  logic             frame_done;
`ifdef SOBEL_THRESH_EN
  logic [OUT_W-1:0] thresh = '0;
  logic             out_edge;
  int               th_sof = 0;
`endif

  sobel_stream_filter #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .PIX_W (PIX_W),
    .OUT_W (OUT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mode       (mode),
`ifdef SOBEL_THRESH_EN
    .thresh     (thresh),
    .out_edge   (out_edge),
`endif
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sof     (in_sof),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  int img [IMG_H][IMG_W];
  int rx_data[$], rx_last[$], rx_edge[$];
  int exp_data[$], exp_last[$];
  int fd_cnt = 0;
  int fd_base;
  int ready_mode = 0;
  logic prev_stall = 1'b0;
  logic [OUT_W-1:0] prev_data = '0;
  int vpat [6] = '{0, 0, 1020, 1020, 0, 0};
  int hpat [4] = '{0, 1020, 1020, 0};

  // Sink: 0 = always ready, 1 = random 50%, 2 = never ready.
  always @(posedge clk) begin
    #1;
    if (ready_mode == 1)      out_ready = ($urandom_range(0, 1) == 1);
    else if (ready_mode == 2) out_ready = 1'b0;
    else                      out_ready = 1'b1;
  end

  // Output monitor: record handshakes, count frame_done, check hold stability.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", int'(out_valid), 1);
        check("hold_data", int'(out_data), int'(prev_data));
      end
      if (out_valid && out_ready) begin
        rx_data.push_back(int'(out_data));
        rx_last.push_back(int'(out_last));
`ifdef SOBEL_THRESH_EN
        rx_edge.push_back(int'(out_edge));
`endif
      end
      if (frame_done) fd_cnt <= fd_cnt + 1;
      prev_stall <= out_valid && !out_ready;
      prev_data  <= out_data;
    end
  end

  task automatic set_img(input int kind);
    for (int r = 0; r < IMG_H; r++) begin
      for (int c = 0; c < IMG_W; c++) begin
        case (kind)
          0: img[r][c] = 128;
          1: img[r][c] = (c < 4) ? 0 : 255;
          2: img[r][c] = (c < 4) ? 255 : 0;
          3: img[r][c] = (r < 3) ? 0 : 255;
          default: img[r][c] = (r * 40 + c * 23) % 256;
        endcase
      end
    end
  endtask

  // Reference: Sobel of the window whose newest pixel is (r,c).
  function automatic int gold(input int r, input int c, input logic [1:0] m);
    int gx, gy, ax, ay;
    gx = (img[r-2][c] + 2 * img[r-1][c] + img[r][c])
       - (img[r-2][c-2] + 2 * img[r-1][c-2] + img[r][c-2]);
    gy = (img[r][c-2] + 2 * img[r][c-1] + img[r][c])
       - (img[r-2][c-2] + 2 * img[r-2][c-1] + img[r-2][c]);
    ax = (gx < 0) ? -gx : gx;
    ay = (gy < 0) ? -gy : gy;
    if (m == 2'b01) return gx & MASK;
    if (m == 2'b10) return gy & MASK;
    return (ax + ay) & MASK;
  endfunction

  task automatic push_exp(input int v, input bit last);
    exp_data.push_back(v & MASK);
    exp_last.push_back(int'(last));
  endtask

  task automatic add_gold(input logic [1:0] m, input int n_max, input bit with_last);
    int n = 0;
    for (int r = 2; r < IMG_H; r++) begin
      for (int c = 2; c < IMG_W; c++) begin
        if (n < n_max) push_exp(gold(r, c, m), with_last && (r == IMG_H - 1) && (c == IMG_W - 1));
        n++;
      end
    end
  endtask

  task automatic start_test();
    rx_data.delete();
    rx_last.delete();
    rx_edge.delete();
    exp_data.delete();
    exp_last.delete();
    fd_base = fd_cnt;
  endtask

  task automatic send_pix(input int d, input bit sof, input bit gaps, input logic [1:0] m);
    int t;
    @(posedge clk);
    #1;
    if (gaps && ($urandom_range(0, 1) == 1)) begin
      in_valid = 1'b0;
      in_sof   = 1'b0;
      repeat ($urandom_range(1, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b1;
    in_sof   = sof;
    in_data  = PIX_W'(d);
    mode     = m;
`ifdef SOBEL_THRESH_EN
    thresh   = sof ? OUT_W'(th_sof) : '0;
`endif
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) check("in_ready_timeout", 0, 1);
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  // Send the current image from (0,0) up to, but excluding, (stop_r, stop_c).
  // Mode is flipped after the sof pixel so a frame that ignores sampling shows it.
  task automatic send_frame(input logic [1:0] m, input bit gaps, input int stop_r, input int stop_c);
    for (int r = 0; r < IMG_H; r++) begin
      for (int c = 0; c < IMG_W; c++) begin
        if (r == stop_r && c == stop_c) return;
        send_pix(img[r][c], (r == 0 && c == 0), gaps, (r == 0 && c == 0) ? m : (m ^ 2'b01));
      end
    end
  endtask

  task automatic wait_rx();
    int t = 0;
    idle();
    while (rx_data.size() < exp_data.size() && t < 300) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic compare(input string tag);
    check({tag, "_count"}, rx_data.size(), exp_data.size());
    for (int i = 0; i < rx_data.size() && i < exp_data.size(); i++) begin
      check($sformatf("%s_data%0d", tag, i), rx_data[i], exp_data[i]);
      check($sformatf("%s_last%0d", tag, i), rx_last[i], exp_last[i]);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values.
    #2 rst_n = 1'b0;
    #10;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_out_last", int'(out_last), 0);
    check("rst_frame_done", int'(frame_done), 0);
    check("rst_in_ready", int'(in_ready), 1);
    #10 rst_n = 1'b1;

    // Flat image with junk pixels before sof: 24 zeros, last on the 24th.
    set_img(0);
    start_test();
    for (int i = 0; i < 3; i++) send_pix(255, 1'b0, 1'b0, 2'b01);
    for (int i = 0; i < 24; i++) push_exp(0, i == 23);
    send_frame(2'b00, 1'b0, 99, 99);
    wait_rx();
    compare("flat");
    check("flat_frame_done", fd_cnt - fd_base, 1);

    // Vertical step, Gx: 0,0,1020,1020,0,0 per output row.
    set_img(1);
    start_test();
    for (int i = 0; i < 24; i++) push_exp(vpat[i % 6], i == 23);
    send_frame(2'b01, 1'b0, 99, 99);
    wait_rx();
    compare("vstep_gx");
    check("vstep_gx_frame_done", fd_cnt - fd_base, 1);

    // Vertical step, Gy: all zero.
    start_test();
    for (int i = 0; i < 24; i++) push_exp(0, i == 23);
    send_frame(2'b10, 1'b0, 99, 99);
    wait_rx();
    compare("vstep_gy");

    // Inverted vertical step, Gx: -1020 in two's complement.
    set_img(2);
    start_test();
    for (int i = 0; i < 24; i++) push_exp(-vpat[i % 6], i == 23);
    send_frame(2'b01, 1'b0, 99, 99);
    wait_rx();
    compare("vstep_neg_gx");

    // Horizontal step, Gy: output rows 0 and 3 zero, rows 1 and 2 at 1020.
    set_img(3);
    start_test();
    for (int i = 0; i < 24; i++) push_exp(hpat[i / 6], i == 23);
    send_frame(2'b10, 1'b0, 99, 99);
    wait_rx();
    compare("hstep_gy");
    check("hstep_frame_done", fd_cnt - fd_base, 1);

    // Ramp image with input gaps and random output backpressure, all modes.
    set_img(4);
    ready_mode = 1;
    for (int m = 0; m < 4; m++) begin
      start_test();
      add_gold(2'(m), 24, 1'b1);
      send_frame(2'(m), 1'b1, 99, 99);
      wait_rx();
      compare($sformatf("ramp_m%0d", m));
      check($sformatf("ramp_m%0d_frame_done", m), fd_cnt - fd_base, 1);
    end
    ready_mode = 0;

    // Abort at (3,5): the (3,4) result still in S1 is dropped, 8 results
    // escape with no last, then the restarted frame runs to completion.
    start_test();
    add_gold(2'b00, 8, 1'b0);
    add_gold(2'b01, 24, 1'b1);
    send_frame(2'b00, 1'b0, 3, 5);
    send_frame(2'b01, 1'b0, 99, 99);
    wait_rx();
    compare("abort");
    check("abort_frame_done", fd_cnt - fd_base, 1);

    // Mid-frame asynchronous reset while the output is stalled.
    ready_mode = 2;
    start_test();
    send_frame(2'b00, 1'b0, 2, 3);
    idle();
    repeat (4) @(negedge clk);
    check("pre_rst_out_valid", int'(out_valid), 1);
    check("pre_rst_in_ready", int'(in_ready), 0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", int'(out_valid), 0);
    check("mid_rst_out_data", int'(out_data), 0);
    check("mid_rst_out_last", int'(out_last), 0);
    check("mid_rst_frame_done", int'(frame_done), 0);
    check("mid_rst_in_ready", int'(in_ready), 1);
    repeat (2) @(negedge clk);
    #2;
    ready_mode = 0;
    rst_n = 1'b1;
    start_test();
    add_gold(2'b10, 24, 1'b1);
    send_frame(2'b10, 1'b0, 99, 99);
    wait_rx();
    compare("post_rst");
    check("post_rst_frame_done", fd_cnt - fd_base, 1);

`ifdef SOBEL_THRESH_EN
    // Threshold 1020 on the vertical step: edge only where magnitude is 1020.
    set_img(1);
    th_sof = 1020;
    start_test();
    for (int i = 0; i < 24; i++) push_exp(vpat[i % 6], i == 23);
    send_frame(2'b00, 1'b0, 99, 99);
    wait_rx();
    compare("thresh");
    for (int i = 0; i < rx_edge.size() && i < 24; i++) begin
      check($sformatf("thresh_edge%0d", i), rx_edge[i], (vpat[i % 6] == 1020) ? 1 : 0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
